// File: rtl/ex_divider.sv
// ex_divider: iterative radix-2 restoring divider for DIV/DIVU in EX.
// One quotient bit per cycle, MSB first, then a sign-fix cycle.
// A start accepted in cycle T gives `done` in cycle T+WIDTH+2.
//
// Optional build macro:
//   DIV_ZERO_FAST_EN - a divide by zero skips CALC/FIX and finishes at T+1.
//                      The results are the same as on the slow path.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         issue request (DIV/DIVU in EX this cycle)
//   div_unsigned  1 = DIVU, 0 = DIV
//   rs_data       dividend
//   rt_data       divisor
//   flush         cancels any operation in flight; takes priority over start
//   busy          stall request, combinational (covers the issue cycle)
//   done          one-cycle pulse; quotient/remainder valid (LO/HI write enable)
//   quotient      to LO, held until the next result
//   remainder     to HI, held until the next result
module ex_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_unsigned,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] qd;       // dividend shifting out at the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg;

    logic             accept;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic             last;
    logic             div_zero_fast;

    always_comb begin
        accept = (state == IDLE || state == DONE) && start && !flush;
        rs_neg = !div_unsigned && rs_data[WIDTH-1];
        rt_neg = !div_unsigned && rt_data[WIDTH-1];
        // Magnitudes are unsigned; abs(most negative) wraps to itself,
        // which is still the correct unsigned magnitude.
        rs_mag = rs_neg ? -rs_data : rs_data;
        rt_mag = rt_neg ? -rt_data : rt_data;

        partial = {rem, qd[WIDTH-1]};
        trial   = partial - {1'b0, dvs};
        // partial < 2*dvs always holds. When partial's top bit is set, the
        // partial remainder is >= 2^WIDTH > dvs, so the subtract always fits.
        // Otherwise the top bit of the (WIDTH+1)-bit difference is the borrow.
        fits    = partial[WIDTH] | ~trial[WIDTH];
        last    = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
        div_zero_fast = (rt_data == '0);
`else
        div_zero_fast = 1'b0;
`endif
    end

    // Next-state logic and outputs
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = div_zero_fast ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            CALC:    if (last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;

        busy = accept || state == CALC || state == FIX;
        done = (state == DONE) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            qd        <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                qd    <= rs_mag;
                dvs   <= rt_mag;
                rem   <= '0;
                cnt   <= '0;
                q_neg <= rs_neg ^ rt_neg;
                r_neg <= rs_neg;
`ifdef DIV_ZERO_FAST_EN
                // Same values the slow path produces for a zero divisor.
                if (div_zero_fast) begin
                    quotient  <= rs_neg ? WIDTH'(1) : '1;
                    remainder <= rs_data;
                end
`endif
            end else if (state == CALC) begin
                rem <= fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
                qd  <= {qd[WIDTH-2:0], fits};
                cnt <= cnt + CW'(1);
            end else if (state == FIX && !flush) begin
                quotient  <= q_neg ? -qd  : qd;
                remainder <= r_neg ? -rem : rem;
            end
        end
    end

endmodule
